// File: rtl/sha3_pkg.sv
// Shared constants and types for the masked SHA3 absorb path: rate sizes
// for the four fixed-output SHA3 variants, the padding bytes and the
// absorb controller state encoding.
package sha3_pkg;

    // Rate in 32-bit words: (1600 - 2*digest_bits) / 32.
    localparam int RATE_WORDS_SHA3_224 = 36;
    localparam int RATE_WORDS_SHA3_256 = 34;
    localparam int RATE_WORDS_SHA3_384 = 26;
    localparam int RATE_WORDS_SHA3_512 = 18;

    // SHA3 domain separation bits plus the first pad10*1 bit.
    localparam logic [7:0] PAD_DOMAIN_SHA3 = 8'h06;
    // Closing pad10*1 bit, always in the last byte of the rate block.
    localparam logic [7:0] PAD_FINAL       = 8'h80;

    // Absorb controller states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_LOAD = 3'd2,
        ST_PAD  = 3'd3,
        ST_PERM = 3'd4,
        ST_FIN  = 3'd5
    } absorb_state_e;

endpackage

// File: rtl/masked_pad_word.sv
// Combinational padding of one Boolean-masked 32-bit word.
// Each share is byte-masked independently; the public padding constants
// go into share 0 only, so the two shares never meet in one logic cone.
module masked_pad_word
    import sha3_pkg::*;
#(
    parameter logic [7:0] DOMAIN_BYTE = PAD_DOMAIN_SHA3
) (
    input  logic [31:0] din_0,
    input  logic [31:0] din_1,
    input  logic [2:0]  nbytes,     // valid low bytes, 4 or more = full word
    input  logic        domain_en,  // insert DOMAIN_BYTE at byte nbytes
    input  logic        final_en,   // word closes the final rate block
    output logic [31:0] dout_0,
    output logic [31:0] dout_1
);

    logic [31:0] keep;
    logic [31:0] domain_word;
    logic [31:0] final_word;
    logic        domain_active;

    // Byte-keep mask derived from the byte count alone (no share data).
    always_comb begin
        // NOTE: assign a default before any conditional update so every path
        // writes keep; otherwise synthesis infers a latch.
        keep = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes) begin
                keep[8*b +: 8] = 8'hFF;
            end
        end
    end

    // The domain byte lands right after the last valid byte; a full word
    // has no room for it and the caller carries it into the next word.
    assign domain_active = domain_en && (nbytes < 3'd4);
    assign domain_word   = domain_active
                         ? ({24'h0, DOMAIN_BYTE} << {nbytes[1:0], 3'b000})
                         : 32'h0;
    assign final_word    = final_en ? {PAD_FINAL, 24'h0} : 32'h0;

    assign dout_0 = (din_0 & keep) ^ domain_word ^ final_word;
    assign dout_1 =  din_1 & keep;

endmodule

// File: rtl/masked_sha3_absorb_ctrl.sv
// Absorb-phase controller for a masked (two-share) Keccak-f[1600] core.
// Takes message words as Boolean shares, pads the final word and the tail
// of the last block, streams padded words to the core one per cycle and
// sequences permutations between rate blocks.
module masked_sha3_absorb_ctrl
    import sha3_pkg::*;
#(
    parameter int         RATE_WORDS  = RATE_WORDS_SHA3_256,
    parameter logic [7:0] DOMAIN_BYTE = PAD_DOMAIN_SHA3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [31:0] msg_0,
    input  logic [31:0] msg_1,
    input  logic        msg_last,
    input  logic [2:0]  msg_bytes,
    output logic        core_init,
    output logic        core_absorb,
    output logic [31:0] core_din_0,
    output logic [31:0] core_din_1,
    output logic        core_go,
    input  logic        core_done,
    output logic        absorb_done
);

    localparam int WCNT_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(RATE_WORDS - 1);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] INIT = ST_INIT;
    localparam logic [2:0] LOAD = ST_LOAD;
    localparam logic [2:0] PAD  = ST_PAD;
    localparam logic [2:0] PERM = ST_PERM;
    localparam logic [2:0] FIN  = ST_FIN;

    logic [2:0]        state;
    logic [WCNT_W-1:0] wcnt;         // index of the next word in the block
    logic              domain_pend;  // domain byte still owed to the next pad word
    logic              pad_pend;     // a full pad block follows this permutation
    logic              final_pend;   // the block being permuted is the last one

    logic              block_end;
    logic              last_full;

    logic [31:0]       pad_in_0;
    logic [31:0]       pad_in_1;
    logic [2:0]        pad_nbytes;
    logic              pad_domain_en;
    logic              pad_final_en;
    logic [31:0]       pad_out_0;
    logic [31:0]       pad_out_1;

    assign block_end = (wcnt == LAST_WCNT);
    assign last_full = (msg_bytes >= 3'd4);

    // Control strobes decoded straight from the state register.
    assign msg_ready   = (state == LOAD);
    assign core_init   = (state == INIT);
    assign absorb_done = (state == FIN);

    // Select what the padder sees: live message shares in LOAD, an all-zero
    // word in PAD (share 1 stays zero, only constants reach share 0).
    always_comb begin
        pad_in_0      = msg_0;
        pad_in_1      = msg_1;
        pad_nbytes    = 3'd4;
        pad_domain_en = 1'b0;
        pad_final_en  = 1'b0;
        if (state == PAD) begin
            pad_in_0      = 32'h0;
            pad_in_1      = 32'h0;
            pad_nbytes    = 3'd0;
            pad_domain_en = domain_pend;
            pad_final_en  = block_end;
        end else if (msg_last) begin
            pad_nbytes    = last_full ? 3'd4 : msg_bytes;
            pad_domain_en = !last_full;
            // A full last word at block end defers all padding to a new block.
            pad_final_en  = block_end && !last_full;
        end
    end

    masked_pad_word #(
        .DOMAIN_BYTE (DOMAIN_BYTE)
    ) u_pad (
        .din_0     (pad_in_0),
        .din_1     (pad_in_1),
        .nbytes    (pad_nbytes),
        .domain_en (pad_domain_en),
        .final_en  (pad_final_en),
        .dout_0    (pad_out_0),
        .dout_1    (pad_out_1)
    );

    // Absorb sequencer: word counting, padding bookkeeping and core handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the word registers drive outputs directly, so they are
            // reset along with the control state to keep stale shares off
            // the core bus after reset.
            state       <= IDLE;
            wcnt        <= '0;
            domain_pend <= 1'b0;
            pad_pend    <= 1'b0;
            final_pend  <= 1'b0;
            core_absorb <= 1'b0;
            core_go     <= 1'b0;
            core_din_0  <= 32'h0;
            core_din_1  <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments only here; every register
            // samples the pre-edge values, whatever the statement order.
            core_absorb <= 1'b0;
            core_go     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= INIT;
                    end
                end

                INIT: begin
                    wcnt        <= '0;
                    domain_pend <= 1'b0;
                    pad_pend    <= 1'b0;
                    final_pend  <= 1'b0;
                    state       <= LOAD;
                end

                LOAD: begin
                    if (msg_valid) begin
                        core_absorb <= 1'b1;
                        core_din_0  <= pad_out_0;
                        core_din_1  <= pad_out_1;
                        if (block_end) begin
                            wcnt    <= '0;
                            core_go <= 1'b1;
                            state   <= PERM;
                            if (msg_last) begin
                                final_pend  <= !last_full;
                                pad_pend    <= last_full;
                                domain_pend <= last_full;
                            end
                        end else begin
                            wcnt <= wcnt + 1'b1;
                            if (msg_last) begin
                                domain_pend <= last_full;
                                state       <= PAD;
                            end
                        end
                    end
                end

                PAD: begin
                    core_absorb <= 1'b1;
                    core_din_0  <= pad_out_0;
                    core_din_1  <= pad_out_1;
                    domain_pend <= 1'b0;
                    if (block_end) begin
                        wcnt       <= '0;
                        core_go    <= 1'b1;
                        final_pend <= 1'b1;
                        state      <= PERM;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end

                PERM: begin
                    // core_go is high only on the first PERM cycle; a done
                    // seen there cannot belong to this permutation.
                    if (core_done && !core_go) begin
                        if (pad_pend) begin
                            pad_pend <= 1'b0;
                            state    <= PAD;
                        end else if (final_pend) begin
                            state <= FIN;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                FIN: begin
                    final_pend <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_sha3_absorb_ctrl.sv
// Self-checking bench for masked_sha3_absorb_ctrl (default SHA3-256 rate).
// Table-driven messages compared against hand-computed key words and a
// byte-level SHA3 padding model, plus hand-written reset sequences.
module tb_masked_sha3_absorb_ctrl;

    localparam int R    = 34;
    localparam int MAXW = 128;

    logic        clk;
    logic        rst;
    logic        start;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] msg_0;
    logic [31:0] msg_1;
    logic        msg_last;
    logic [2:0]  msg_bytes;
    logic        core_init;
    logic        core_absorb;
    logic [31:0] core_din_0;
    logic [31:0] core_din_1;
    logic        core_go;
    logic        core_done;
    logic        absorb_done;

    logic        model_done;
    logic        inject_done;
    int          perm_delay;

    int          n_checks;
    int          n_pass;

    // Monitor state
    logic [31:0] cap0 [MAXW];
    logic [31:0] cap1 [MAXW];
    int          n_cap;
    int          go_cnt;
    int          done_cnt;
    int          init_cnt;
    int          perm_viol;
    bit          perm_busy;

    assign core_done = model_done | inject_done;

    masked_sha3_absorb_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .msg_valid   (msg_valid),
        .msg_ready   (msg_ready),
        .msg_0       (msg_0),
        .msg_1       (msg_1),
        .msg_last    (msg_last),
        .msg_bytes   (msg_bytes),
        .core_init   (core_init),
        .core_absorb (core_absorb),
        .core_din_0  (core_din_0),
        .core_din_1  (core_din_1),
        .core_go     (core_go),
        .core_done   (core_done),
        .absorb_done (absorb_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Keccak core stand-in: done pulse perm_delay cycles after core_go,
    // abandoned if reset arrives meanwhile.
    initial begin
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            if (core_go && !rst) begin
                for (int k = 0; k < perm_delay; k++) begin
                    @(posedge clk);
                    if (rst) break;
                end
                if (!rst) begin
                    #1 model_done = 1'b1;
                    @(posedge clk);
                    #1 model_done = 1'b0;
                end
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            n_cap     = 0;
            go_cnt    = 0;
            done_cnt  = 0;
            init_cnt  = 0;
            perm_viol = 0;
            perm_busy = 1'b0;
        end else begin
            if (perm_busy && (msg_ready || core_absorb)) perm_viol++;
            if (core_done) perm_busy = 1'b0;
            if (core_go) begin
                perm_busy = 1'b1;
                go_cnt++;
            end
            if (core_absorb) begin
                if (n_cap < MAXW) begin
                    cap0[n_cap] = core_din_0;
                    cap1[n_cap] = core_din_1;
                end
                n_cap++;
            end
            if (absorb_done) done_cnt++;
            if (core_init) init_cnt++;
        end
    end

    typedef struct {
        int          n_full;      // full non-last words before the last word
        int          last_bytes;
        logic [31:0] last_val;    // plain value of the last word
        int          pdelay;
        int          exp_go;
        logic [31:0] exp_first;   // combined word 0
        logic [31:0] exp_w33;     // combined word 33
        logic [31:0] exp_w34;     // combined word 34 (two-block cases)
        logic [31:0] exp_final;   // combined last strobed word
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] word_val(input int i);
        return 32'(i + 1) * 32'h01020304;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctl"}, {27'h0, msg_ready, core_init, core_absorb, core_go, absorb_done}, 32'h0);
        check({name, "_din"}, core_din_0 | core_din_1, 32'h0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Present one word and hold it until accepted; msg_valid stays high.
    task automatic send_word(input logic [31:0] v, input logic [31:0] m,
                             input bit last, input logic [2:0] nb);
        bit got;
        msg_0     = v ^ m;
        msg_1     = m;
        msg_last  = last;
        msg_bytes = nb;
        msg_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (msg_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ready_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vector(input vec_t v, input int idx, input bit with_reset);
        logic [31:0] masks [MAXW];
        logic [7:0]  pb [MAXW*4];
        logic [31:0] w;
        logic [31:0] exp1;
        logic [31:0] got_final;
        int          len, nblk, plen, nw, bad;
        string       tag;

        tag = $sformatf("v%0d", idx);
        if (with_reset) apply_reset();
        perm_delay = v.pdelay;
        for (int i = 0; i <= v.n_full; i++) masks[i] = $urandom;

        do_start();
        for (int i = 0; i < v.n_full; i++) send_word(word_val(i), masks[i], 1'b0, 3'd0);
        send_word(v.last_val, masks[v.n_full], 1'b1, 3'(v.last_bytes));
        msg_valid = 1'b0;
        msg_last  = 1'b0;

        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;

        // Independent model: byte stream with SHA3 pad10*1 applied.
        len  = 4 * v.n_full + v.last_bytes;
        nblk = (len + 1 + 4 * R - 1) / (4 * R);
        plen = nblk * 4 * R;
        nw   = plen / 4;
        for (int i = 0; i < plen; i++) pb[i] = 8'h00;
        for (int i = 0; i < v.n_full; i++) begin
            w = word_val(i);
            for (int b = 0; b < 4; b++) pb[4*i + b] = w[8*b +: 8];
        end
        w = v.last_val;
        for (int b = 0; b < v.last_bytes; b++) pb[4*v.n_full + b] = w[8*b +: 8];
        pb[len]      = pb[len] ^ 8'h06;
        pb[plen - 1] = pb[plen - 1] ^ 8'h80;

        bad = 0;
        for (int k = 0; k < nw && k < n_cap && k < MAXW; k++) begin
            w = {pb[4*k+3], pb[4*k+2], pb[4*k+1], pb[4*k]};
            if (k < v.n_full) exp1 = masks[k];
            else if (k == v.n_full) begin
                exp1 = masks[k];
                for (int b = v.last_bytes; b < 4; b++) exp1[8*b +: 8] = 8'h00;
            end else exp1 = 32'h0;
            if ((cap0[k] ^ cap1[k]) !== w || cap1[k] !== exp1) bad++;
        end

        got_final = (n_cap > 0 && n_cap <= MAXW) ? (cap0[n_cap-1] ^ cap1[n_cap-1]) : 32'hxxxxxxxx;

        check({tag, "_strobes"}, 32'(n_cap), 32'(v.exp_go * R));
        check({tag, "_model_strobes"}, 32'(n_cap), 32'(nw));
        check({tag, "_core_go"}, 32'(go_cnt), 32'(v.exp_go));
        check({tag, "_core_init"}, 32'(init_cnt), 32'd1);
        check({tag, "_absorb_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_perm_quiet"}, 32'(perm_viol), 32'd0);
        check({tag, "_word0"}, cap0[0] ^ cap1[0], v.exp_first);
        check({tag, "_word33"}, cap0[33] ^ cap1[33], v.exp_w33);
        if (v.exp_go == 2) check({tag, "_word34"}, cap0[34] ^ cap1[34], v.exp_w34);
        check({tag, "_final_word"}, got_final, v.exp_final);
        check({tag, "_stream_errors"}, 32'(bad), 32'd0);
        check({tag, "_word0_share1_byte3"}, {24'h0, cap1[0][31:24]},
              (v.n_full == 0 && v.last_bytes < 4) ? 32'h0 : {24'h0, masks[0][31:24]});
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        msg_valid   = 1'b0;
        msg_0       = 32'h0;
        msg_1       = 32'h0;
        msg_last    = 1'b0;
        msg_bytes   = 3'd0;
        inject_done = 1'b0;
        perm_delay  = 5;

        // n_full, last_bytes, last_val, pdelay, exp_go, first, w33, w34, final
        vecs[0] = '{0,  0, 32'h00000000, 5,  1, 32'h00000006, 32'h80000000, 32'h0,        32'h80000000};
        vecs[1] = '{0,  3, 32'hFF636261, 5,  1, 32'h06636261, 32'h80000000, 32'h0,        32'h80000000};
        vecs[2] = '{0,  4, 32'h11223344, 4,  1, 32'h11223344, 32'h80000000, 32'h0,        32'h80000000};
        vecs[3] = '{0,  1, 32'hDEADBEEF, 3,  1, 32'h000006EF, 32'h80000000, 32'h0,        32'h80000000};
        vecs[4] = '{0,  2, 32'hDEADBEEF, 2,  1, 32'h0006BEEF, 32'h80000000, 32'h0,        32'h80000000};
        vecs[5] = '{33, 3, 32'h00ABCDEF, 6,  1, 32'h01020304, 32'h86ABCDEF, 32'h0,        32'h86ABCDEF};
        vecs[6] = '{33, 4, 32'h12345678, 3,  2, 32'h01020304, 32'h12345678, 32'h00000006, 32'h80000000};
        vecs[7] = '{40, 0, 32'hCAFEF00D, 24, 2, 32'h01020304, 32'h22446688, 32'h2346698C, 32'h80000000};

        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vector(vecs[i], i, 1'b1);

        // Reset in the middle of LOAD, with word 10 about to be accepted.
        apply_reset();
        perm_delay = 5;
        do_start();
        for (int i = 0; i < 10; i++) send_word(word_val(i), $urandom, 1'b0, 3'd0);
        check("midload_strobe_live", {31'h0, core_absorb}, 32'h1);
        rst       = 1'b1;
        msg_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_outputs_zero("midload_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        run_vector(vecs[1], 8, 1'b0);

        // Reset in the middle of PERM, then a stray core_done right after.
        apply_reset();
        perm_delay = 60;
        do_start();
        for (int i = 0; i < R; i++) send_word(word_val(i), $urandom, 1'b0, 3'd0);
        msg_valid = 1'b0;
        for (int k = 0; k < 200 && go_cnt == 0; k++) @(negedge clk);
        check("midperm_go_seen", 32'(go_cnt), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        inject_done = 1'b1;
        @(negedge clk);
        check_outputs_zero("midperm_rst");
        @(posedge clk);
        #1 inject_done = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_done_absorb", 32'(n_cap), 32'd0);
        check("stray_done_fin", 32'(done_cnt), 32'd0);
        check("stray_done_ready", {31'h0, msg_ready}, 32'h0);
        @(posedge clk);
        #1;
        run_vector(vecs[0], 9, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
